// File: rtl/ccip_arb_pkg.sv
// Shared types and helpers for the CCI-P read/write request arbiters.
// mdata layout is {seq, requester id}; rr_pick is the round-robin grant rule.
package ccip_arb_pkg;

    localparam int unsigned REQ_ID_W  = 4;
    localparam int unsigned SEQ_W     = 12;
    localparam int unsigned MAX_REQ   = 1 << REQ_ID_W;
    localparam int unsigned CL_ADDR_W = 42;

    typedef struct packed {
        logic [SEQ_W-1:0]    seq;
        logic [REQ_ID_W-1:0] id;
    } t_arb_mdata;

    // One-hot grant of the first valid requester at or after ptr, modulo n.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0]  valid,
        input logic [REQ_ID_W-1:0] ptr,
        input int unsigned         n
    );
        logic [MAX_REQ-1:0] grant;
        logic               found;
        int unsigned        idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                idx = (32'(ptr) + k) % n;
                if (!found && valid[idx[REQ_ID_W-1:0]]) begin
                    grant[idx[REQ_ID_W-1:0]] = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/ccip_rd_arbiter_rr_arbiter.sv
// Parameterised round-robin grant with its rotating priority pointer.
// The pointer moves to one past the winner only when a grant is issued.
module rr_arbiter
    import ccip_arb_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] grant,
    output logic         accept
);

    logic [REQ_ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [REQ_ID_W-1:0] grant_idx;
    logic [MAX_REQ-1:0]  pick;

    always_comb begin
        pick      = rr_pick(MAX_REQ'(req), rr_ptr_q, N);
        grant     = en ? pick[N-1:0] : '0;
        accept    = en && (|pick);
        grant_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant[i]) grant_idx = REQ_ID_W'(i);
        end
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (grant_idx == REQ_ID_W'(N - 1)) ? '0 : grant_idx + REQ_ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) rr_ptr_q <= '0;
        else       rr_ptr_q <= rr_ptr_d;
    end

endmodule

// File: rtl/ccip_rd_arbiter.sv
// Round-robin sharing of the CCI-P c0 read-request channel with response routing by mdata.
// Define CCIP_RD_ARB_STATS_EN to build per-requester issued-request counters.
module ccip_rd_arbiter
    import ccip_arb_pkg::*;
#(
    parameter int unsigned N_REQ           = 4,
    parameter int unsigned MAX_OUTSTANDING = 256
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*CL_ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       c0_tx_valid,
    output logic [CL_ADDR_W-1:0]       c0_tx_addr,
    output logic [15:0]                c0_tx_mdata,
    input  logic                       c0_tx_almfull,
    input  logic                       c0_rx_rdvalid,
    input  logic [15:0]                c0_rx_mdata,
    input  logic [511:0]               c0_rx_data,
    output logic [N_REQ-1:0]           rsp_valid,
    output logic [511:0]               rsp_data,
    output logic [SEQ_W-1:0]           rsp_seq,
    output logic [N_REQ*32-1:0]        stat_issued
);

    localparam int unsigned OUT_W = 10;

    logic                 allow;
    logic                 accept;
    t_arb_mdata           rx_mdata;

    logic [OUT_W-1:0]     outstanding_q, outstanding_d;
    logic [SEQ_W-1:0]     seq_q [N_REQ];
    logic [SEQ_W-1:0]     seq_d [N_REQ];
    logic                 c0_tx_valid_q, c0_tx_valid_d;
    logic [CL_ADDR_W-1:0] c0_tx_addr_q, c0_tx_addr_d;
    t_arb_mdata           c0_tx_mdata_q, c0_tx_mdata_d;
    logic [N_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [511:0]         rsp_data_q, rsp_data_d;
    logic [SEQ_W-1:0]     rsp_seq_q, rsp_seq_d;

    // almfull gates issue in the same cycle it is seen
    always_comb begin
        allow = !c0_tx_almfull && (outstanding_q < OUT_W'(MAX_OUTSTANDING));
    end

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr_arbiter (
        .clk    (clk),
        .reset  (reset),
        .req    (req_valid),
        .en     (allow),
        .grant  (req_ready),
        .accept (accept)
    );

    always_comb begin
        rx_mdata      = c0_rx_mdata;
        c0_tx_valid_d = accept;
        c0_tx_addr_d  = c0_tx_addr_q;
        c0_tx_mdata_d = c0_tx_mdata_q;
        seq_d         = seq_q;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (req_ready[i]) begin
                c0_tx_addr_d  = req_addr[i*CL_ADDR_W +: CL_ADDR_W];
                c0_tx_mdata_d = '{seq: seq_q[i], id: REQ_ID_W'(i)};
                seq_d[i]      = seq_q[i] + SEQ_W'(1);
            end
        end

        // Ids beyond N_REQ still update data/seq and the count, but never strobe
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_seq_d   = rsp_seq_q;
        if (c0_rx_rdvalid) begin
            rsp_data_d = c0_rx_data;
            rsp_seq_d  = rx_mdata.seq;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (rx_mdata.id == REQ_ID_W'(i)) rsp_valid_d[i] = 1'b1;
            end
        end

        outstanding_d = outstanding_q;
        if (accept && !c0_rx_rdvalid) begin
            outstanding_d = outstanding_q + OUT_W'(1);
        end else if (!accept && c0_rx_rdvalid && (outstanding_q != '0)) begin
            outstanding_d = outstanding_q - OUT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding_q <= '0;
            c0_tx_valid_q <= 1'b0;
            c0_tx_addr_q  <= '0;
            c0_tx_mdata_q <= '0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
            rsp_seq_q     <= '0;
            for (int unsigned i = 0; i < N_REQ; i++) seq_q[i] <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            c0_tx_valid_q <= c0_tx_valid_d;
            c0_tx_addr_q  <= c0_tx_addr_d;
            c0_tx_mdata_q <= c0_tx_mdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_seq_q     <= rsp_seq_d;
            seq_q         <= seq_d;
        end
    end

    always_comb begin
        c0_tx_valid = c0_tx_valid_q;
        c0_tx_addr  = c0_tx_addr_q;
        c0_tx_mdata = c0_tx_mdata_q;
        rsp_valid   = rsp_valid_q;
        rsp_data    = rsp_data_q;
        rsp_seq     = rsp_seq_q;
    end

`ifdef CCIP_RD_ARB_STATS_EN
    logic [31:0] stat_q [N_REQ];
    logic [31:0] stat_d [N_REQ];

    always_comb begin
        stat_d      = stat_q;
        stat_issued = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (req_ready[i]) stat_d[i] = stat_q[i] + 32'd1;
            stat_issued[i*32 +: 32] = stat_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_REQ; i++) stat_q[i] <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end
`else
    always_comb begin
        stat_issued = '0;
    end
`endif

endmodule

// File: tb/tb_ccip_rd_arbiter.sv
// Self-checking bench for ccip_rd_arbiter (N_REQ=4, MAX_OUTSTANDING=2) against a cycle-level reference model.
module tb_ccip_rd_arbiter;

    localparam int N       = 4;
    localparam int MAX_OUT = 2;

    logic              clk;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N*42-1:0]   req_addr;
    logic [N-1:0]      req_ready;
    logic              c0_tx_valid;
    logic [41:0]       c0_tx_addr;
    logic [15:0]       c0_tx_mdata;
    logic              c0_tx_almfull;
    logic              c0_rx_rdvalid;
    logic [15:0]       c0_rx_mdata;
    logic [511:0]      c0_rx_data;
    logic [N-1:0]      rsp_valid;
    logic [511:0]      rsp_data;
    logic [11:0]       rsp_seq;
    logic [N*32-1:0]   stat_issued;

    ccip_rd_arbiter #(
        .N_REQ           (N),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_ready     (req_ready),
        .c0_tx_valid   (c0_tx_valid),
        .c0_tx_addr    (c0_tx_addr),
        .c0_tx_mdata   (c0_tx_mdata),
        .c0_tx_almfull (c0_tx_almfull),
        .c0_rx_rdvalid (c0_rx_rdvalid),
        .c0_rx_mdata   (c0_rx_mdata),
        .c0_rx_data    (c0_rx_data),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_seq       (rsp_seq),
        .stat_issued   (stat_issued)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_ptr;
    int          m_out;
    logic [11:0] m_seq  [N];
    logic [31:0] m_stat [N];
    logic [15:0] iss_q  [$];
    logic        e_tx_valid;
    logic [41:0] e_tx_addr;
    logic [15:0] e_tx_mdata;
    logic [N-1:0] e_rsp_valid;
    logic [511:0] e_rsp_data;
    logic [11:0] e_rsp_seq;

    function automatic logic [N-1:0] model_grant();
        logic [N-1:0] g;
        g = '0;
        if (!c0_tx_almfull && m_out < MAX_OUT) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (req_valid[idx] && g == '0) g[idx] = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic logic [511:0] rand_line();
        logic [511:0] d;
        for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [N*32-1:0] model_stats();
        logic [N*32-1:0] s;
        s = '0;
`ifdef CCIP_RD_ARB_STATS_EN
        for (int i = 0; i < N; i++) s[i*32 +: 32] = m_stat[i];
`endif
        return s;
    endfunction

    // Advance one clock and update the model; leaves time at posedge+1.
    task automatic tick();
        logic [N-1:0] g;
        int gi;
        g = model_grant();
        @(posedge clk);
        if (reset) begin
            m_ptr = 0;
            m_out = 0;
            for (int i = 0; i < N; i++) begin
                m_seq[i]  = '0;
                m_stat[i] = '0;
            end
            iss_q.delete();
            e_tx_valid = 1'b0; e_tx_addr = '0; e_tx_mdata = '0;
            e_rsp_valid = '0; e_rsp_data = '0; e_rsp_seq = '0;
        end else begin
            e_tx_valid = (g != '0);
            if (g != '0) begin
                gi = 0;
                for (int i = 0; i < N; i++) if (g[i]) gi = i;
                e_tx_addr  = req_addr[gi*42 +: 42];
                e_tx_mdata = {m_seq[gi], 4'(gi)};
                iss_q.push_back(e_tx_mdata);
                m_seq[gi]  = m_seq[gi] + 12'd1;
                m_stat[gi] = m_stat[gi] + 32'd1;
                m_ptr      = (gi + 1) % N;
            end
            e_rsp_valid = '0;
            if (c0_rx_rdvalid) begin
                e_rsp_data = c0_rx_data;
                e_rsp_seq  = c0_rx_mdata[15:4];
                if (int'(c0_rx_mdata[3:0]) < N) e_rsp_valid[c0_rx_mdata[1:0]] = 1'b1;
            end
            if (g != '0 && !c0_rx_rdvalid) m_out++;
            else if (g == '0 && c0_rx_rdvalid && m_out > 0) m_out--;
        end
        #1;
    endtask

    task automatic set_idle();
        req_valid = '0; req_addr = '0; c0_tx_almfull = 1'b0;
        c0_rx_rdvalid = 1'b0; c0_rx_mdata = '0; c0_rx_data = '0;
    endtask

    // Retire everything in flight with dropped-id responses (no strobe).
    task automatic drain();
        req_valid = '0; c0_rx_rdvalid = 1'b1; c0_rx_mdata = 16'h000F;
        repeat (MAX_OUT + 1) tick();
        c0_rx_rdvalid = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        checks++;
        if ({c0_tx_valid, c0_tx_addr, c0_tx_mdata} !== '0) begin
            errors++; $display("FAIL reset_tx: got v=%b a=%h m=%h exp all 0", c0_tx_valid, c0_tx_addr, c0_tx_mdata);
        end
        checks++;
        if (rsp_valid !== '0 || rsp_data !== '0 || rsp_seq !== '0) begin
            errors++; $display("FAIL reset_rsp: got v=%b seq=%h exp 0", rsp_valid, rsp_seq);
        end
        checks++;
        if (stat_issued !== '0) begin
            errors++; $display("FAIL reset_stat: got %h exp 0", stat_issued);
        end
    endtask

    task automatic test_single();
        logic [511:0] d;
        req_valid = 4'b0010; req_addr[1*42 +: 42] = 42'h100;
        #1; checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_ready: got %b exp 0010", req_ready); end
        tick(); checks++;
        if (c0_tx_valid !== 1'b1 || c0_tx_addr !== 42'h100 || c0_tx_mdata !== 16'h0001) begin
            errors++; $display("FAIL single_tx1: got v=%b a=%h m=%h exp 1/100/0001", c0_tx_valid, c0_tx_addr, c0_tx_mdata);
        end
        req_addr[1*42 +: 42] = 42'h200;
        tick(); checks++;
        if (c0_tx_valid !== 1'b1 || c0_tx_addr !== 42'h200 || c0_tx_mdata !== 16'h0011) begin
            errors++; $display("FAIL single_tx2: got v=%b a=%h m=%h exp 1/200/0011", c0_tx_valid, c0_tx_addr, c0_tx_mdata);
        end
        #1; checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL cap_stall: got %b exp 0000", req_ready); end
        tick(); checks++;
        if (c0_tx_valid !== 1'b0) begin errors++; $display("FAIL cap_txvalid: got %b exp 0", c0_tx_valid); end
        d = rand_line();
        c0_rx_rdvalid = 1'b1; c0_rx_mdata = 16'h0032; c0_rx_data = d;
        tick();
        c0_rx_rdvalid = 1'b0; checks++;
        if (rsp_valid !== 4'b0100 || rsp_seq !== 12'd3 || rsp_data !== d) begin
            errors++; $display("FAIL cap_rsp: got v=%b seq=%0d data_ok=%b exp 0100/3/1", rsp_valid, rsp_seq, rsp_data === d);
        end
        #1; checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL cap_resume: got %b exp 0010", req_ready); end
        tick(); checks++;
        if (c0_tx_valid !== 1'b1 || c0_tx_mdata !== 16'h0021) begin
            errors++; $display("FAIL cap_tx3: got v=%b m=%h exp 1/0021", c0_tx_valid, c0_tx_mdata);
        end
        drain();
    endtask

    task automatic test_simultaneous();
        req_valid = 4'b0001;
        tick();
        c0_rx_rdvalid = 1'b1; c0_rx_mdata = 16'h0005;
        #1; checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL simul_ready: got %b exp 0001", req_ready); end
        tick();
        c0_rx_rdvalid = 1'b0; checks++;
        if (rsp_valid !== '0 || c0_tx_valid !== 1'b1) begin
            errors++; $display("FAIL simul_badid: got rsp_v=%b tx_v=%b exp 0000/1", rsp_valid, c0_tx_valid);
        end
        #1; checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL simul_count: got %b exp 0001", req_ready); end
        tick(); #1; checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL simul_full: got %b exp 0000", req_ready); end
        drain();
    endtask

    task automatic test_fairness();
        reset = 1'b1; tick(); reset = 1'b0;
        req_valid = 4'b1111; c0_rx_rdvalid = 1'b1; c0_rx_mdata = 16'h000F;
        for (int k = 0; k < 8; k++) begin
            logic [N-1:0] exp_g;
            exp_g = '0; exp_g[k % N] = 1'b1;
            #1; checks++;
            if (req_ready !== exp_g) begin errors++; $display("FAIL fair_grant%0d: got %b exp %b", k, req_ready, exp_g); end
            tick(); checks++;
            if (c0_tx_valid !== 1'b1 || int'(c0_tx_mdata[3:0]) != k % N) begin
                errors++; $display("FAIL fair_tx%0d: got v=%b id=%0d exp 1/%0d", k, c0_tx_valid, c0_tx_mdata[3:0], k % N);
            end
        end
        #1; checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL fair_wrap: got %b exp 0001", req_ready); end
    endtask

    task automatic test_almfull();
        tick(); tick();
        c0_tx_almfull = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1; checks++;
            if (req_ready !== 4'b0000) begin errors++; $display("FAIL almfull_%0d: got %b exp 0000", k, req_ready); end
            tick();
        end
        c0_tx_almfull = 1'b0;
        #1; checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL almfull_resume: got %b exp 0100", req_ready); end
        tick();
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) req_addr[i*42 +: 42] = {10'($urandom), 32'($urandom)};
            c0_tx_almfull = ($urandom % 5 == 0);
            c0_rx_rdvalid = 1'b0;
            c0_rx_data    = rand_line();
            if (iss_q.size() > 0 && $urandom % 2 == 0) begin
                c0_rx_rdvalid = 1'b1; c0_rx_mdata = iss_q.pop_front();
            end else if ($urandom % 8 == 0) begin
                c0_rx_rdvalid = 1'b1; c0_rx_mdata = 16'($urandom);
            end
            #1; checks++;
            if (req_ready !== model_grant()) begin
                errors++; $display("FAIL rnd_ready c%0d: got %b exp %b", c, req_ready, model_grant());
            end
            tick(); checks++;
            if (c0_tx_valid !== e_tx_valid || (e_tx_valid && (c0_tx_addr !== e_tx_addr || c0_tx_mdata !== e_tx_mdata))) begin
                errors++; $display("FAIL rnd_tx c%0d: got %b/%h/%h exp %b/%h/%h", c, c0_tx_valid, c0_tx_addr, c0_tx_mdata, e_tx_valid, e_tx_addr, e_tx_mdata);
            end
            checks++;
            if (rsp_valid !== e_rsp_valid || rsp_seq !== e_rsp_seq || rsp_data !== e_rsp_data) begin
                errors++; $display("FAIL rnd_rsp c%0d: got v=%b seq=%h exp v=%b seq=%h", c, rsp_valid, rsp_seq, e_rsp_valid, e_rsp_seq);
            end
            checks++;
            if (stat_issued !== model_stats()) begin
                errors++; $display("FAIL rnd_stat c%0d: got %h exp %h", c, stat_issued, model_stats());
            end
        end
        set_idle();
        drain();
    endtask

    task automatic test_reset_midop();
        logic [15:0]  saved;
        logic [511:0] d;
        logic [N-1:0] exp_v;
        req_valid = 4'b0011;
        tick(); tick();
        saved = e_tx_mdata;
        req_valid = '0; reset = 1'b1;
        tick();
        reset = 1'b0; checks++;
        if ({c0_tx_valid, c0_tx_mdata, rsp_valid, rsp_seq} !== '0 || stat_issued !== '0) begin
            errors++; $display("FAIL midrst_out: got tx_v=%b m=%h rsp_v=%b stat=%h exp 0", c0_tx_valid, c0_tx_mdata, rsp_valid, stat_issued);
        end
        d = rand_line();
        c0_rx_rdvalid = 1'b1; c0_rx_mdata = saved; c0_rx_data = d;
        tick();
        c0_rx_rdvalid = 1'b0;
        exp_v = '0; exp_v[saved[1:0]] = 1'b1;
        checks++;
        if (rsp_valid !== exp_v || rsp_seq !== saved[15:4] || rsp_data !== d) begin
            errors++; $display("FAIL midrst_route: got v=%b seq=%h exp v=%b seq=%h", rsp_valid, rsp_seq, exp_v, saved[15:4]);
        end
        req_valid = 4'b1111;
        #1; checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL midrst_nounderflow: got %b exp 0001", req_ready); end
        tick(); #1; checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL midrst_issue2: got %b exp 0010", req_ready); end
        tick(); #1; checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL midrst_cap: got %b exp 0000", req_ready); end
        set_idle();
    endtask

    initial begin
        reset = 1'b1;
        set_idle();
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_almfull();
        test_random();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ccip_rd_arbiter.md
# ccip_rd_arbiter

Round-robin arbiter that shares the CCI-P c0 (read-request) Tx channel among `N_REQ` AFU read engines inside `wrapper`. It tags each request's mdata with the requester index. It enforces the c0 almost-full backpressure and a global outstanding-read cap. It routes c0 read responses back to the issuing requester. It sits between the AFU engines and the registered CCI-P ports that feed `pck_af2cp_sTx` and `pck_cp2af_sRx`.

## Interface
- `N_REQ`, 4: number of requesters, 2..16.
- `MAX_OUTSTANDING`, 256: cap on in-flight reads, 1..1023.
- `clk` in 1: single clock, pClk domain; everything is synchronous to its rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in N_REQ: per-requester read request pending.
- `req_addr` in N_REQ×42: cache-line address (t_ccip_clAddr) per requester.
- `req_ready` out N_REQ: one-hot grant; a request is accepted when valid & ready.
- `c0_tx_valid` out 1: read request valid to CCI-P c0 Tx.
- `c0_tx_addr` out 42: granted address.
- `c0_tx_mdata` out 16: {12'(seq), 4'(requester id)}.
- `c0_tx_almfull` in 1: c0TxAlmFull from the Rx port.
- `c0_rx_rdvalid` in 1: read response valid, already filtered to resp_type = eRSP_RDLINE.
- `c0_rx_mdata` in 16: response mdata.
- `c0_rx_data` in 512: response cache line.
- `rsp_valid` out N_REQ: one-hot response strobe.
- `rsp_data` out 512: response data, shared by all requesters.
- `rsp_seq` out 12: sequence field echoed from mdata.
- `stat_issued` out N_REQ×32: per-requester issued-request count; see Configuration.

## Operation
- `allow` = !c0_tx_almfull && (outstanding < MAX_OUTSTANDING).
- Grant logic:
  - Combinational round-robin from `rr_ptr`.
  - Grants the first asserted `req_valid` at or after `rr_ptr`, wrapping modulo N_REQ.
  - `req_ready` is all-zero when `!allow`.
- On accept by requester i:
  - Register `c0_tx_valid`=1, `c0_tx_addr`=req_addr[i], `c0_tx_mdata`={seq[i], i}.
  - `seq[i]` increments and wraps at 4096.
  - `rr_ptr` ← (i+1) mod N_REQ.
  - `outstanding` increments.
- With no accept in a cycle, the next-cycle `c0_tx_valid`=0 and `rr_ptr` holds.
- Response routing, on `c0_rx_rdvalid`:
  - Register `rsp_valid[c0_rx_mdata[3:0]]`=1, `rsp_data`=c0_rx_data, `rsp_seq`=c0_rx_mdata[15:4].
  - An id ≥ N_REQ is dropped; no strobe.
  - `outstanding` decrements, saturating at 0.
- Issue and response in the same cycle: `outstanding` is unchanged.
- Reset values: outputs, `outstanding`, `rr_ptr`, all `seq`, and stats are 0.
- Reset mid-operation: responses to pre-reset requests are still routed by mdata; the counter does not underflow.

## Timing
- Request path: accept cycle T → `c0_tx_valid` at T+1, registered.
- Response path: `c0_rx_rdvalid` at T → `rsp_valid` at T+1, registered.
- `c0_tx_almfull` is used the same cycle it is seen. Issue stops the cycle almfull is high, which leaves one possible in-flight request from the previous accept; this is within the CCI-P allowance.
- Throughput: one request per cycle when `allow` holds.
- Requesters may hold `req_valid` with a changing address until accepted; the address is sampled only in the accept cycle.

## Configuration
- `CCIP_RD_ARB_STATS_EN` defined:
  - One 32-bit wrapping counter per requester, incremented on each accept.
  - Driven on `stat_issued`; cleared by reset.
- Undefined: no counters are built and `stat_issued` is tied to 0.
- Arbitration behaviour is identical in both builds.

## Structure
- Shared package `ccip_arb_pkg`:
  - `REQ_ID_W`=4 and `SEQ_W`=12.
  - Typedef `t_arb_mdata` = packed {seq, id}.
  - Function `rr_pick(valid, ptr)`, returning the one-hot grant.
- One natural sub-module, `rr_arbiter`: the parameterised round-robin grant plus `rr_ptr` register, reusable for c1 write arbitration later.

## Test plan
- Single requester, N_REQ=4: req 1 valid, addr 0x100 → ready[1] in the same cycle; next cycle `c0_tx_valid`=1, addr 0x100, mdata 0x0001. A second accept gives mdata 0x0011.
- Fairness: all four valid for 8 cycles → grants 0,1,2,3,0,1,2,3 and `rr_ptr` wraps to 0.
- Almfull: assert `c0_tx_almfull` for 5 cycles with all valid → `req_ready` is 0 for exactly those cycles. Deassert → grant resumes at the saved `rr_ptr`.
- Cap: MAX_OUTSTANDING=2, no responses → exactly 2 issues and then a stall. One response with mdata 0x0032 → `rsp_valid[2]`, `rsp_seq`=3, and one more issue follows.
- Simultaneous issue and response at outstanding=MAX-1 → count stays MAX-1; responses with id 5 (N_REQ=4) produce no strobe.
- Reset asserted with 3 outstanding → all outputs 0. A post-reset response is routed correctly and `outstanding` stays 0; with `CCIP_RD_ARB_STATS_EN`, `stat_issued` reads 0 after reset.
